// File: rtl/icache_refill_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_assembler
//  Description : Collects 64-bit AXI R beats into one I$ refill line, tracking
//                {nc, tid} of every granted read request in order, and hands
//                the finished line downstream with valid/ready and error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_assembler #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned REQ_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // request side (AR grant)
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_nc_i,
    input  logic [ID_WIDTH-1:0]   req_tid_i,
    // R beat side
    input  logic                  beat_valid_i,
    output logic                  beat_ready_o,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    input  logic                  beat_last_i,
    input  logic                  beat_err_i,
    // line return side
    output logic                  rtrn_valid_o,
    input  logic                  rtrn_ready_i,
    output logic [LINE_WIDTH-1:0] rtrn_data_o,
    output logic [ID_WIDTH-1:0]   rtrn_tid_o,
    output logic                  rtrn_nc_o,
    output logic                  rtrn_err_o,
    output logic                  busy_o
);

    localparam int unsigned c_NB   = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned c_CW   = $clog2(c_NB) + 1;
    localparam int unsigned c_PW   = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned c_QW   = $clog2(REQ_DEPTH + 1);
    localparam int unsigned c_EW   = ID_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // request FIFO storage: entry = {nc, tid}
    logic [c_EW-1:0]     r_mem [REQ_DEPTH];
    logic [c_PW-1:0]     r_wr_ptr;
    logic [c_PW-1:0]     r_rd_ptr;
    logic [c_QW-1:0]     r_count;
    logic [c_QW-1:0]     w_count_nxt;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [c_EW-1:0]     w_head;
    logic                w_head_nc;

    // line assembly state
    logic [c_CW-1:0]     r_cnt;
    logic [LINE_WIDTH-1:0] r_data;
    logic                r_err;

    logic                w_beat_ready;
    logic                w_rtrn_valid;
    logic                w_beat_acc;
    logic [c_CW-1:0]     w_limit_m1;
    logic                w_wr_en;
    logic                w_len_err;

    // ------------------------------------------------------------------------
    // FIFO status and handshakes; ready depends on registered state only
    // ------------------------------------------------------------------------
    assign w_full    = (r_count == c_QW'(REQ_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid_i & ~w_full;
    assign w_pop     = w_rtrn_valid & rtrn_ready_i;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_nc = w_head[ID_WIDTH];

    // Occupancy after this cycle's push/pop, also used to pick HOLD's exit
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_QW'(1);
            2'b01:   w_count_nxt = r_count - c_QW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PW'(REQ_DEPTH - 1)) ? '0 : r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PW'(REQ_DEPTH - 1)) ? '0 : r_rd_ptr + c_PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO payload; contents are meaningless while the entry is not counted
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_nc_i, req_tid_i};
        end
    end

    // ------------------------------------------------------------------------
    // Beat acceptance and length checking
    // ------------------------------------------------------------------------
    // The last legal word index is 0 for nc heads, NB-1 for cacheable heads.
    // A non-last beat landing on that index, or any beat beyond it, is a
    // length error and its data is dropped.
    assign w_beat_acc = w_beat_ready & beat_valid_i;
    assign w_limit_m1 = w_head_nc ? '0 : c_CW'(c_NB - 1);
    assign w_wr_en    = (r_cnt < w_limit_m1) || ((r_cnt == w_limit_m1) && beat_last_i);
    assign w_len_err  = beat_last_i ? (r_cnt != w_limit_m1) : (r_cnt >= w_limit_m1);

    // Line data, beat counter and sticky error; cleared when the line leaves
    always_ff @(posedge clk_i) begin
        if (rst_i || w_pop) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_beat_acc) begin
            for (int k = 0; k < int'(c_NB); k++) begin
                if (w_wr_en && (r_cnt == c_CW'(k))) begin
                    r_data[k*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
                end
            end
            if (r_cnt != {c_CW{1'b1}}) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            r_err <= r_err | beat_err_i | w_len_err;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_beat_ready = 1'b0;
        w_rtrn_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                w_beat_ready = 1'b1;
                if (beat_valid_i && beat_last_i) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_rtrn_valid = 1'b1;
                if (rtrn_ready_i) begin
                    w_state_nxt = (w_count_nxt != '0) ? ST_COLLECT : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs; head tid/nc are only presented while a line is on offer
    // ------------------------------------------------------------------------
    assign req_ready_o  = ~w_full;
    assign beat_ready_o = w_beat_ready;
    assign rtrn_valid_o = w_rtrn_valid;
    assign rtrn_data_o  = r_data;
    assign rtrn_tid_o   = w_rtrn_valid ? w_head[ID_WIDTH-1:0] : '0;
    assign rtrn_nc_o    = w_rtrn_valid & w_head_nc;
    assign rtrn_err_o   = r_err;
    assign busy_o       = ~w_empty | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_assembler
//  Description : Directed scoreboard bench for icache_refill_assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_assembler;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tid;
        logic         nc;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_nc = 1'b0;
    logic [3:0]   req_tid = '0;
    logic         beat_valid = 1'b0;
    logic         beat_ready;
    logic [63:0]  beat_data = '0;
    logic         beat_last = 1'b0;
    logic         beat_err = 1'b0;
    logic         rtrn_valid;
    logic         rtrn_ready = 1'b1;
    logic [127:0] rtrn_data;
    logic [3:0]   rtrn_tid;
    logic         rtrn_nc;
    logic         rtrn_err;
    logic         busy;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    localparam logic [63:0] A0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] A1 = 64'hFEDC_BA98_7654_3210;

    icache_refill_assembler dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_nc_i     (req_nc),
        .req_tid_i    (req_tid),
        .beat_valid_i (beat_valid),
        .beat_ready_o (beat_ready),
        .beat_data_i  (beat_data),
        .beat_last_i  (beat_last),
        .beat_err_i   (beat_err),
        .rtrn_valid_o (rtrn_valid),
        .rtrn_ready_i (rtrn_ready),
        .rtrn_data_o  (rtrn_data),
        .rtrn_tid_o   (rtrn_tid),
        .rtrn_nc_o    (rtrn_nc),
        .rtrn_err_o   (rtrn_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed return handshake is checked against the queue head
    always @(negedge clk) begin
        if (!rst && rtrn_valid && rtrn_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_line: got tid %h with no line expected", rtrn_tid);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("line_data", rtrn_data, e.data);
                chk("line_tid", 128'(rtrn_tid), 128'(e.tid));
                chk("line_nc", 128'(rtrn_nc), 128'(e.nc));
                chk("line_err", 128'(rtrn_err), 128'(e.err));
            end
        end
    end

    function automatic exp_t mk(input logic [127:0] d, input logic [3:0] t, input logic n, input logic e);
        exp_t x;
        x.data = d; x.tid = t; x.nc = n; x.err = e;
        return x;
    endfunction

    // All tasks start and end at posedge+1
    task automatic push(input logic nc, input logic [3:0] tid);
        int t = 0;
        req_valid = 1'b1; req_nc = nc; req_tid = tid;
        while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) chk("push_timeout", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic last, input logic err);
        int t = 0;
        beat_valid = 1'b1; beat_data = d; beat_last = last; beat_err = err;
        while (!beat_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) chk("beat_timeout", 128'(beat_ready), 128'(1));
        @(posedge clk); #1;
        beat_valid = 1'b0; beat_last = 1'b0; beat_err = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || q.size() != 0) && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) chk(name, 128'(q.size()), 128'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"},  128'(req_ready),  128'(1));
        chk({tag, "_beat_ready"}, 128'(beat_ready), 128'(0));
        chk({tag, "_rtrn_valid"}, 128'(rtrn_valid), 128'(0));
        chk({tag, "_rtrn_data"},  rtrn_data,        128'(0));
        chk({tag, "_rtrn_tid"},   128'(rtrn_tid),   128'(0));
        chk({tag, "_rtrn_nc"},    128'(rtrn_nc),    128'(0));
        chk({tag, "_rtrn_err"},   128'(rtrn_err),   128'(0));
        chk({tag, "_busy"},       128'(busy),       128'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("reset");

        // 1: cacheable two-beat line, latency check
        q.push_back(mk({A1, A0}, 4'd3, 1'b0, 1'b0));
        push(1'b0, 4'd3);
        beat(A0, 1'b0, 1'b0);
        chk("t1_valid_before_last", 128'(rtrn_valid), 128'(0));
        beat(A1, 1'b1, 1'b0);
        chk("t1_valid_after_last", 128'(rtrn_valid), 128'(1));
        wait_idle("t1_drain");

        // 2: non-cacheable single beat
        q.push_back(mk({64'h0, 64'hDEAD}, 4'd5, 1'b1, 1'b0));
        push(1'b1, 4'd5);
        beat(64'hDEAD, 1'b1, 1'b0);
        wait_idle("t2_drain");

        // 3: bus error on beat 0, then short cacheable burst
        q.push_back(mk({64'h2222, 64'h1111}, 4'd7, 1'b0, 1'b1));
        push(1'b0, 4'd7);
        beat(64'h1111, 1'b0, 1'b1);
        beat(64'h2222, 1'b1, 1'b0);
        q.push_back(mk({64'h0, 64'h3333}, 4'd8, 1'b0, 1'b1));
        push(1'b0, 4'd8);
        beat(64'h3333, 1'b1, 1'b0);
        wait_idle("t3_drain");

        // 4: two outstanding requests, consumer stalls 4 cycles in HOLD
        rtrn_ready = 1'b0;
        q.push_back(mk({64'hB1, 64'hA1}, 4'd1, 1'b0, 1'b0));
        q.push_back(mk({64'hB2, 64'hA2}, 4'd2, 1'b0, 1'b0));
        push(1'b0, 4'd1);
        push(1'b0, 4'd2);
        chk("t4_req_ready_full", 128'(req_ready), 128'(0));
        beat(64'hA1, 1'b0, 1'b0);
        beat(64'hB1, 1'b1, 1'b0);
        fork
            begin
                beat(64'hA2, 1'b0, 1'b0);
                beat(64'hB2, 1'b1, 1'b0);
            end
            begin
                repeat (4) begin
                    chk("t4_beat_ready_hold", 128'(beat_ready), 128'(0));
                    chk("t4_valid_hold", 128'(rtrn_valid), 128'(1));
                    chk("t4_tid_hold", 128'(rtrn_tid), 128'(1));
                    @(posedge clk); #1;
                end
                rtrn_ready = 1'b1;
            end
        join
        wait_idle("t4_drain");

        // 5: push offered while full in the cycle of the return handshake
        rtrn_ready = 1'b0;
        q.push_back(mk({64'h9B, 64'h9A}, 4'd9, 1'b0, 1'b0));
        q.push_back(mk({64'h0, 64'hAA}, 4'd10, 1'b1, 1'b0));
        q.push_back(mk({64'hBB2, 64'hBB1}, 4'd11, 1'b0, 1'b0));
        push(1'b0, 4'd9);
        push(1'b1, 4'd10);
        beat(64'h9A, 1'b0, 1'b0);
        beat(64'h9B, 1'b1, 1'b0);
        chk("t5_full_at_handshake", 128'(req_ready), 128'(0));
        rtrn_ready = 1'b1;
        push(1'b0, 4'd11);
        beat(64'hAA, 1'b1, 1'b0);
        beat(64'hBB1, 1'b0, 1'b0);
        beat(64'hBB2, 1'b1, 1'b0);
        wait_idle("t5_drain");

        // 6: reset mid-burst, then a fresh request
        push(1'b0, 4'd4);
        beat(64'h4444, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("midrst");
        q.push_back(mk({64'h6B, 64'h6A}, 4'd6, 1'b0, 1'b0));
        push(1'b0, 4'd6);
        beat(64'h6A, 1'b0, 1'b0);
        beat(64'h6B, 1'b1, 1'b0);
        wait_idle("t6_drain");

        chk("final_queue_empty", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
